cv32e40p_mutsel_ctrl: RTL and testbench

Campaign sequencer for the MCY decoder mutation harness. It drives the `mutsel` select of the mutated cv32e40p decoder through indices 1..NUM_MUTATIONS and gates an instruction stimulus stream into that decoder and a golden decoder. Each cycle it compares packed output signatures from the two decoders. For each mutation it reports whether that mutation was detected, and on which instruction it was first detected.

---
 rtl/cv32e40p_mcy_pkg.sv | 32 +++
 rtl/cv32e40p_mutsel_window.sv | 50 +++++
 rtl/cv32e40p_mutsel_ctrl.sv | 131 +++++++++++++
 tb/tb_cv32e40p_mutsel_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_mcy_pkg.sv
// Shared types for the MCY decoder mutation harness: controller states,
// mutation-select constants and the packed decoder-output signature.
package cv32e40p_mcy_pkg;

  localparam int MUTSEL_W = 8;
  localparam logic [MUTSEL_W-1:0] MUTSEL_NONE = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN,
    ST_REPORT,
    ST_DONE
  } mutsel_ctrl_state_e;

  // Decoder outputs as concatenated by the harness top; golden and mutant
  // signatures are built with the same layout so a plain compare suffices.
  typedef struct packed {
    logic [31:0] imm;
    logic [6:0]  alu_operator;
    logic [11:0] alu_mux_sel;
    logic [2:0]  mult_operator;
    logic [15:0] ctrl_flags;
    logic [7:0]  data_ctrl;
    logic [3:0]  csr_ctrl;
    logic [7:0]  exc_flags;
    logic [5:0]  misc;
  } decoder_sig_t;

  localparam int DECODER_SIG_W = $bits(decoder_sig_t);

endpackage

// File: rtl/cv32e40p_mutsel_window.sv
// Per-mutation compare window: counts transfers, flags the window end and
// captures the instruction number of the first mismatch.
module cv32e40p_mutsel_window #(
  parameter int WINDOW_LEN = 256,
  parameter bit EARLY_EXIT = 1'b1,
  localparam int CNT_W = $clog2(WINDOW_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             xfer,
  input  logic             mismatch,
  output logic             win_end,
  output logic             det,
  output logic [CNT_W-1:0] first
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_LEN - 1);
  localparam logic [CNT_W-1:0] NONE = CNT_W'(WINDOW_LEN);

  logic [CNT_W-1:0] cnt_q, first_q;
  logic             det_q;
  logic             hit;

  assign hit = xfer & mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      first_q <= '0;
      det_q   <= 1'b0;
    end else if (clear) begin
      cnt_q   <= '0;
      first_q <= NONE;
      det_q   <= 1'b0;
    end else if (xfer) begin
      cnt_q <= cnt_q + 1'b1;
      if (hit && !det_q) begin
        det_q   <= 1'b1;
        first_q <= cnt_q;
      end
    end
  end

  // Include the current transfer so the closing cycle reports its own mismatch.
  assign det     = det_q | hit;
  assign first   = det_q ? first_q : (hit ? cnt_q : NONE);
  assign win_end = xfer & ((cnt_q == LAST) | (EARLY_EXIT & mismatch));

endmodule

// File: rtl/cv32e40p_mutsel_ctrl.sv
// Mutation campaign sequencer: steps mutsel through 1..NUM_MUTATIONS, gates
// the stimulus into both decoders and reports per-mutation detection results.
module cv32e40p_mutsel_ctrl
  import cv32e40p_mcy_pkg::*;
#(
  parameter int NUM_MUTATIONS = 64,
  parameter int WINDOW_LEN    = 256,
  parameter int SIG_W         = 96,
  parameter bit EARLY_EXIT    = 1'b1,
  localparam int FIRST_W = $clog2(WINDOW_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [SIG_W-1:0]   golden_sig_i,
  input  logic [SIG_W-1:0]   mutant_sig_i,
  output logic [7:0]         mutsel_o,
  output logic               win_start_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [7:0]         result_idx_o,
  output logic               result_detected_o,
  output logic [FIRST_W-1:0] result_first_o,
  output logic [7:0]         detected_cnt_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [MUTSEL_W-1:0] LAST_IDX = MUTSEL_W'(NUM_MUTATIONS);

  mutsel_ctrl_state_e state_q, state_d;

  logic [MUTSEL_W-1:0] idx_q, det_cnt_q, res_idx_q;
  logic                res_det_q;
  logic [FIRST_W-1:0]  res_first_q;

  logic               camp_start, capture, accept;
  logic               in_run, in_window, xfer, mismatch;
  logic               win_end, win_det;
  logic [FIRST_W-1:0] win_first;

  assign in_run    = (state_q == ST_RUN);
  assign in_window = (state_q == ST_SETUP) | in_run | (state_q == ST_REPORT);
  assign xfer      = in_run & instr_valid_i & ~abort_i;
  assign mismatch  = (golden_sig_i != mutant_sig_i);

  cv32e40p_mutsel_window #(
    .WINDOW_LEN (WINDOW_LEN),
    .EARLY_EXIT (EARLY_EXIT)
  ) u_window (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state_q == ST_SETUP),
    .xfer     (xfer),
    .mismatch (mismatch),
    .win_end  (win_end),
    .det      (win_det),
    .first    (win_first)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    camp_start = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: if (start_i) begin
          state_d    = ST_SETUP;
          camp_start = 1'b1;
        end
        ST_SETUP: state_d = ST_RUN;
        ST_RUN: if (win_end) begin
          state_d = ST_REPORT;
          capture = 1'b1;
        end
        ST_REPORT: if (result_ready_i) begin
          accept  = 1'b1;
          state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_SETUP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Abort leaves the counters alone; only a new start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      det_cnt_q   <= '0;
      res_idx_q   <= '0;
      res_det_q   <= 1'b0;
      res_first_q <= '0;
    end else begin
      if (camp_start) begin
        idx_q     <= MUTSEL_W'(1);
        det_cnt_q <= '0;
      end else if (accept) begin
        if (res_det_q && (det_cnt_q != '1)) det_cnt_q <= det_cnt_q + 1'b1;
        if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
      end
      if (capture) begin
        res_idx_q   <= idx_q;
        res_det_q   <= win_det;
        res_first_q <= win_first;
      end
    end
  end

  assign mutsel_o          = in_window ? idx_q : MUTSEL_NONE;
  assign win_start_o       = (state_q == ST_SETUP);
  assign instr_ready_o     = in_run & ~abort_i;
  assign result_valid_o    = (state_q == ST_REPORT);
  assign result_idx_o      = res_idx_q;
  assign result_detected_o = res_det_q;
  assign result_first_o    = res_first_q;
  assign detected_cnt_o    = det_cnt_q;
  assign busy_o            = in_window;
  assign done_o            = (state_q == ST_DONE);

endmodule

// File: tb/tb_cv32e40p_mutsel_ctrl.sv
// Bench for cv32e40p_mutsel_ctrl: an early-exit and a full-window instance
// share one stimulus stream and are checked against a campaign-level model.
module tb_cv32e40p_mutsel_ctrl;

  localparam int NM = 3;
  localparam int W  = 4;
  localparam int FW = $clog2(W + 1);
  localparam int PH_IDLE = 0, PH_SETUP = 1, PH_RUN = 2, PH_REPORT = 3, PH_DONE = 4;

  logic clk, rst_n, start, abort, instr_valid, result_ready;
  logic          instr_ready [2], win_start [2], result_valid [2], result_det [2];
  logic          busy [2], done [2];
  logic [7:0]    mutsel [2], result_idx [2], det_cnt [2];
  logic [FW-1:0] result_first [2];
  logic [95:0]   gsig [2], msig [2];

  int scen;
  int ptr [2], ws_cnt [2];
  int m_ph [2], m_idx [2], m_n [2], m_cnt [2];
  int r_det [2][4], r_first [2][4], r_xf [2][4];
  int n_checks, n_fail;

  cv32e40p_mutsel_ctrl #(.NUM_MUTATIONS(NM), .WINDOW_LEN(W), .SIG_W(96), .EARLY_EXIT(1'b1)) u_dut_ee (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready[0]),
    .golden_sig_i(gsig[0]), .mutant_sig_i(msig[0]), .mutsel_o(mutsel[0]),
    .win_start_o(win_start[0]), .result_valid_o(result_valid[0]), .result_ready_i(result_ready),
    .result_idx_o(result_idx[0]), .result_detected_o(result_det[0]), .result_first_o(result_first[0]),
    .detected_cnt_o(det_cnt[0]), .busy_o(busy[0]), .done_o(done[0]));

  cv32e40p_mutsel_ctrl #(.NUM_MUTATIONS(NM), .WINDOW_LEN(W), .SIG_W(96), .EARLY_EXIT(1'b0)) u_dut_ne (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready[1]),
    .golden_sig_i(gsig[1]), .mutant_sig_i(msig[1]), .mutsel_o(mutsel[1]),
    .win_start_o(win_start[1]), .result_valid_o(result_valid[1]), .result_ready_i(result_ready),
    .result_idx_o(result_idx[1]), .result_detected_o(result_det[1]), .result_first_o(result_first[1]),
    .detected_cnt_o(det_cnt[1]), .busy_o(busy[1]), .done_o(done[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Which (mutation, instruction) pairs the mutant decoder gets wrong.
  function automatic bit mis(int s, int sel, int i);
    case (s)
      1:       return (sel == 2) && (i == 2);
      2:       return ((sel == 1) && (i == 1 || i == 3)) || ((sel == 3) && (i == 3));
      3:       return (sel == 1) && (i == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int exp_first(int s, int sel);
    for (int i = 0; i < W; i++) if (mis(s, sel, i)) return i;
    return W;
  endfunction

  // Transfers a window takes: instance 0 exits early on a detection.
  function automatic int win_len(int d, int s, int sel);
    int f;
    f = exp_first(s, sel);
    return (d == 0 && f < W) ? f + 1 : W;
  endfunction

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      gsig[d] = {3{32'(ptr[d]) * 32'h9e3779b1}};
      msig[d] = gsig[d] ^ (96'(mis(scen, int'(mutsel[d]), ptr[d])) << 70);
    end
  end

  // Stimulus source, result log and campaign model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_ph[d] <= PH_IDLE; m_idx[d] <= 0; m_n[d] <= 0; m_cnt[d] <= 0; ptr[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (win_start[d]) begin
          ptr[d]    <= 0;
          ws_cnt[d] <= ws_cnt[d] + 1;
        end else if (instr_valid && instr_ready[d]) ptr[d] <= ptr[d] + 1;
        if (result_valid[d] && result_ready && result_idx[d] <= 8'(NM)) begin
          r_det[d][int'(result_idx[d])]   <= int'(result_det[d]);
          r_first[d][int'(result_idx[d])] <= int'(result_first[d]);
          r_xf[d][int'(result_idx[d])]    <= ptr[d];
        end
        if (abort) m_ph[d] <= PH_IDLE;
        else case (m_ph[d])
          PH_IDLE, PH_DONE: if (start) begin
            m_ph[d] <= PH_SETUP; m_idx[d] <= 1; m_cnt[d] <= 0;
          end
          PH_SETUP: begin m_ph[d] <= PH_RUN; m_n[d] <= 0; end
          PH_RUN: if (instr_valid) begin
            m_n[d] <= m_n[d] + 1;
            if (m_n[d] + 1 == win_len(d, scen, m_idx[d])) m_ph[d] <= PH_REPORT;
          end
          PH_REPORT: if (result_ready) begin
            if (exp_first(scen, m_idx[d]) < W && m_cnt[d] < 255) m_cnt[d] <= m_cnt[d] + 1;
            if (m_idx[d] == NM) m_ph[d] <= PH_DONE;
            else begin m_idx[d] <= m_idx[d] + 1; m_ph[d] <= PH_SETUP; end
          end
          default: m_ph[d] <= PH_IDLE;
        endcase
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      int ph;
      bit win;
      ph  = m_ph[d];
      win = (ph == PH_SETUP || ph == PH_RUN || ph == PH_REPORT);
      chk($sformatf("d%0d_mutsel", d), int'(mutsel[d]), win ? m_idx[d] : 0);
      chk($sformatf("d%0d_win_start", d), int'(win_start[d]), int'(ph == PH_SETUP));
      chk($sformatf("d%0d_instr_ready", d), int'(instr_ready[d]), int'(ph == PH_RUN && !abort));
      chk($sformatf("d%0d_result_valid", d), int'(result_valid[d]), int'(ph == PH_REPORT));
      chk($sformatf("d%0d_det_cnt", d), int'(det_cnt[d]), m_cnt[d]);
      chk($sformatf("d%0d_busy", d), int'(busy[d]), int'(win));
      chk($sformatf("d%0d_done", d), int'(done[d]), int'(ph == PH_DONE));
      if (ph == PH_REPORT) begin
        chk($sformatf("d%0d_result_idx", d), int'(result_idx[d]), m_idx[d]);
        chk($sformatf("d%0d_result_det", d), int'(result_det[d]), int'(exp_first(scen, m_idx[d]) < W));
        chk($sformatf("d%0d_result_first", d), int'(result_first[d]), exp_first(scen, m_idx[d]));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int budget);
    int n;
    n = 0;
    while (!(done[0] && done[1]) && n < budget) begin tick(); n++; end
    chk("wait_done_timeout", int'(n >= budget), 0);
  endtask

  task automatic run_campaign(int s);
    scen = s; instr_valid = 1'b1; result_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(200);
  endtask

  initial begin
    int ws0, n, hold;
    n_checks = 0; n_fail = 0; scen = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; instr_valid = 1'b0; result_ready = 1'b0;
    fork
      forever begin @(negedge clk); compare_all(); end
      begin
        tick(); tick();
        chk("reset_mutsel", int'(mutsel[0]), 0);
        chk("reset_done", int'(done[1]), 0);
        rst_n = 1'b1;
        tick();

        // Clean campaign: nothing detected.
        ws0 = ws_cnt[0];
        run_campaign(0);
        chk("t1_ws_pulses", ws_cnt[0] - ws0, 3);
        for (int i = 1; i <= NM; i++) begin
          chk($sformatf("t1_det_%0d", i), r_det[0][i], 0);
          chk($sformatf("t1_first_%0d", i), r_first[1][i], 4);
        end
        chk("t1_cnt", int'(det_cnt[0]), 0);
        chk("t1_done", int'(done[0]), 1);
        chk("t1_mutsel", int'(mutsel[1]), 0);

        // Mutation 2 caught on instruction 2.
        ws0 = ws_cnt[0];
        run_campaign(1);
        chk("t2_det2", r_det[0][2], 1);
        chk("t2_first2_ee", r_first[0][2], 2);
        chk("t2_first2_ne", r_first[1][2], 2);
        chk("t2_xf2_ee", r_xf[0][2], 3);
        chk("t2_ws_pulses", ws_cnt[0] - ws0, 3);
        chk("t2_cnt", int'(det_cnt[0]), 1);

        // Two mismatches in one window; a final-instruction mismatch.
        run_campaign(2);
        chk("t3_first1_ne", r_first[1][1], 1);
        chk("t3_xf1_ne", r_xf[1][1], 4);
        chk("t3_xf1_ee", r_xf[0][1], 2);
        chk("t3_first3", r_first[0][3], 3);
        chk("t3_det3", r_det[1][3], 1);
        chk("t3_cnt", int'(det_cnt[1]), 2);

        // Throttled stimulus and a stalled consumer.
        scen = 0; result_ready = 1'b1; start = 1'b1; tick(); start = 1'b0;
        n = 0; hold = -1;
        while (!(done[0] && done[1]) && n < 300) begin
          instr_valid = n[0];
          if (result_valid[0] && hold < 0) begin result_ready = 1'b0; hold = 0; end
          if (hold >= 0 && hold < 10) begin
            chk("t4_hold_first", int'(result_first[0]), 4);
            chk("t4_hold_mutsel", int'(mutsel[0]), 1);
            hold++;
          end else if (hold == 10) begin
            result_ready = 1'b1; hold = 11;
          end
          tick(); n++;
        end
        chk("t4_timeout", int'(n >= 300), 0);
        chk("t4_first2", r_first[0][2], 4);

        // Abort on instruction 1 of mutation 2, then restart.
        scen = 3; instr_valid = 1'b1; result_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!(mutsel[0] == 8'd2 && instr_ready[0] && ptr[0] == 1) && n < 50) begin tick(); n++; end
        chk("t5_timeout", int'(n >= 50), 0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5_mutsel", int'(mutsel[0]), 0);
        chk("t5_valid", int'(result_valid[0]), 0);
        chk("t5_busy", int'(busy[1]), 0);
        chk("t5_cnt_kept", int'(det_cnt[0]), 1);
        start = 1'b1; tick(); start = 1'b0;
        chk("t5_restart_mutsel", int'(mutsel[0]), 1);
        wait_done(200);
        chk("t5_first1", r_first[0][1], 0);

        // Asynchronous reset while a result is pending.
        scen = 0; start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!result_valid[0] && n < 50) begin tick(); n++; end
        chk("t6_timeout", int'(n >= 50), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", int'(result_valid[0]), 0);
        chk("t6_rst_mutsel", int'(mutsel[0]), 0);
        chk("t6_rst_idx", int'(result_idx[1]), 0);
        chk("t6_rst_first", int'(result_first[0]), 0);
        chk("t6_rst_busy", int'(busy[0]), 0);
        tick(); rst_n = 1'b1; tick();
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!instr_ready[0] && n < 20) begin tick(); n++; end
        start = 1'b1; tick(); start = 1'b0;
        chk("t6_start_ignored", int'(mutsel[0]), 1);
        wait_done(200);
        chk("t6_done", int'(done[0]), 1);
        tick();
      end
    join_any
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
